// File: rtl/config_request_sequencer_pkg.sv
// Shared configuration types: the config bus access type and the sequencer state encoding.
package config_request_sequencer_pkg;

    typedef enum logic {
        T_LOAD  = 1'b0,
        T_STORE = 1'b1
    } config_type_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_ST,
        ISSUE_LD,
        RESP
    } seq_state_e;

endpackage

// File: rtl/config_request_sequencer_if.sv
// Config bus between the request sequencer (master) and the uncached configuration register unit (slave).
interface config_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    import config_request_sequencer_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    config_type_e          config_type;
    logic                  read_valid;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output addr, data, valid, config_type,
        input  read_valid, read_data
    );

    modport slave (
        input  addr, data, valid, config_type,
        output read_valid, read_data
    );

endinterface

// File: rtl/config_request_sequencer.sv
// Sequences one MMIO config request at a time onto config_if and returns exactly one response per request.
module config_request_sequencer
    import config_request_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    config_if.master              conf
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            resp_valid       <= 1'b0;
            resp_data        <= '0;
            resp_err         <= 1'b0;
            conf.valid       <= 1'b0;
            conf.addr        <= '0;
            conf.data        <= '0;
            conf.config_type <= T_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        conf.addr        <= req_addr;
                        conf.data        <= req_data;
                        conf.config_type <= req_is_store ? T_STORE : T_LOAD;
                        cnt              <= '0;
                        // Misaligned requests are answered directly and never reach the bus
                        if (req_addr[2:0] != 3'b000) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state      <= req_is_store ? ISSUE_ST : ISSUE_LD;
                            conf.valid <= 1'b1;
                        end
                    end
                end
                ISSUE_ST: begin
                    conf.valid <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                end
                ISSUE_LD: begin
                    if (conf.read_valid) begin
                        conf.valid <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= conf.read_data;
                    end else if (cnt == CNT_LAST) begin
                        conf.valid <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/config_request_sequencer.md
Name: config_request_sequencer

Overview:
- Sits directly upstream of the uncached configuration register unit, as master of its config_if.
- Accepts one MMIO configuration request at a time from the core-side request channel and drives it onto config_if. Stores are one-cycle pulses; loads are held until read_valid is returned or a timeout expires.
- Returns exactly one response per request on a valid/ready channel, carrying load data or an error flag.

Parameters:
- ADDR_WIDTH, 32, width of the request/config address.
- DATA_WIDTH, 64, width of request data, config data and response data.
- TIMEOUT_CYCLES, 16, maximum conf.valid hold cycles for a load before an error response; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_is_store  input  1  1 = store (T_STORE), 0 = load (T_LOAD)
- req_addr  input  ADDR_WIDTH  byte address
- req_data  input  DATA_WIDTH  store data, ignored for loads
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed when resp_valid && resp_ready
- resp_data  output  DATA_WIDTH  load data; 0 for stores and errors
- resp_err  output  1  1 = misaligned address or load timeout
- conf  config_if.master  -  drives addr, data, valid, config_type; samples read_valid, read_data

Behaviour:
- Reset values (rst sampled high at posedge clk): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, conf.valid=0, conf.addr=0, conf.data=0, conf.config_type=T_LOAD, timeout counter=0.
- Reset asserted mid-operation abandons the transaction: no response, conf.valid low the next cycle.
- All outputs are registered except req_ready, which is (state==IDLE).
- FSM states: IDLE, ISSUE_ST, ISSUE_LD, RESP.
- IDLE, on handshake: latch addr, data, type.
  - addr[2:0] != 0: go to RESP with resp_err=1, resp_data=0. Config bus is never driven.
  - Aligned store: go to ISSUE_ST.
  - Aligned load: go to ISSUE_LD with counter=0.
- ISSUE_ST: conf.valid=1 and config_type=T_STORE for exactly one cycle; then RESP with err=0, data=0. Request-to-conf.valid latency is 1 cycle.
- ISSUE_LD: conf.valid=1, config_type=T_LOAD, held every cycle. Each cycle:
  - conf.read_valid=1: capture conf.read_data into resp_data, err=0, go to RESP. conf.valid drops the next cycle.
  - Otherwise, counter == TIMEOUT_CYCLES-1: go to RESP with err=1, data=0.
  - Otherwise, counter++.
  - conf.valid is therefore asserted for at most TIMEOUT_CYCLES cycles.
- RESP: resp_valid=1, resp_data/resp_err held stable until resp_ready. On handshake go to IDLE; a new request is accepted no earlier than the next cycle.
- One outstanding request only. req_* is ignored outside IDLE. resp_ready is ignored unless resp_valid.
- conf.addr and conf.data hold the latched values from acceptance until the next acceptance. conf.data is don't-care for loads but driven with the latched req_data.
- Counter width: $clog2(TIMEOUT_CYCLES)+1; it never wraps.

Decomposition:
- Shared config package: existing config_type enum (T_LOAD, T_STORE); new state typedef seq_state_e {IDLE, ISSUE_ST, ISSUE_LD, RESP}.
- Single module, no sub-module; the FSM and counter are too small to split.

Test Plan:
- Store: req_is_store=1, addr=0x10, data=0xDEAD_BEEF, resp_ready=1 -> conf.valid high exactly 1 cycle with T_STORE, addr=0x10, data=0xDEAD_BEEF; then resp_valid=1, err=0, data=0; downstream register 2 reads 0xDEAD_BEEF.
- Load hit: addr=0x8, downstream returns read_valid with read_data=0x1234 in the first ISSUE_LD cycle -> conf.valid high 1 cycle; resp_data=0x1234, err=0.
- Load timeout: addr=0x400 never answered, TIMEOUT_CYCLES=16 -> conf.valid high exactly 16 cycles; then resp_err=1, resp_data=0.
- Misaligned: addr=0x13 -> conf.valid never asserts; next cycle resp_valid=1, err=1.
- Backpressure: resp_ready=0 for 5 cycles after a load returning 0xABCD, with req_valid held high with a second request -> resp held stable, req_ready=0 throughout; second request accepted the cycle after the response handshake.
- Reset mid-load: rst=1 during ISSUE_LD -> next cycle conf.valid=0, resp_valid=0, req_ready=1, no response ever emitted.
